// File: rtl/param_reservation_station.sv
// DEPTH-entry Tomasulo reservation station: operand capture, CDB snoop, lowest-index dispatch.
// Optional issue-time CDB bypass selected by defining RS_CDB_BYPASS_EN.
module param_reservation_station #(
    parameter int DATA_W   = 8,
    parameter int TAG_W    = 3,
    parameter int DEPTH    = 2,
    parameter int TAG_BASE = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    output logic [TAG_W-1:0]                   issue_tag,
    input  logic [DATA_W-1:0]                  Operand3,
    input  logic [DATA_W-1:0]                  Operand4,
    input  logic [TAG_W-1:0]                   Operand3_Tag,
    input  logic [TAG_W-1:0]                   Operand4_Tag,
    input  logic                               Operand3_Vbit,
    input  logic                               Operand4_Vbit,
    input  logic                               cdb_valid,
    input  logic [TAG_W-1:0]                   cdb_tag,
    input  logic [DATA_W-1:0]                  cdb_data,
    input  logic                               fu_busy,
    output logic                               dispatch_valid,
    output logic [TAG_W-1:0]                   dispatch_tag,
    output logic [DATA_W-1:0]                  dispatch_op3,
    output logic [DATA_W-1:0]                  dispatch_op4,
    output logic                               rs_full,
    output logic [$clog2(DEPTH+1)-1:0]         rs_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAG_W-1:0] BASE = TAG_W'(TAG_BASE);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  v3;
    logic [DEPTH-1:0]  v4;
    logic [DATA_W-1:0] val3 [DEPTH];
    logic [DATA_W-1:0] val4 [DEPTH];
    logic [TAG_W-1:0]  tag3 [DEPTH];
    logic [TAG_W-1:0]  tag4 [DEPTH];

    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  rdy_idx;
    logic              any_free;
    logic              any_rdy;
    logic [DEPTH-1:0]  snoop3;
    logic [DEPTH-1:0]  snoop4;
    logic [CNT_W-1:0]  count;
    logic              byp3;
    logic              byp4;
    logic              in_v3;
    logic              in_v4;
    logic [DATA_W-1:0] in_val3;
    logic [DATA_W-1:0] in_val4;
    logic              do_issue;
    logic              do_disp;

    // Lowest-index free / ready selection and occupancy, all from pre-edge state.
    always_comb begin
        free_idx = '0;
        rdy_idx  = '0;
        any_free = 1'b0;
        any_rdy  = 1'b0;
        count    = '0;
        snoop3   = '0;
        snoop4   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
            if (busy[i] && v3[i] && v4[i]) begin
                rdy_idx = IDX_W'(i);
                any_rdy = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            count     = count + CNT_W'(busy[i]);
            snoop3[i] = busy[i] && !v3[i] && cdb_valid && (tag3[i] == cdb_tag);
            snoop4[i] = busy[i] && !v4[i] && cdb_valid && (tag4[i] == cdb_tag);
        end
    end

`ifdef RS_CDB_BYPASS_EN
    assign byp3        = !Operand3_Vbit && cdb_valid && (Operand3_Tag == cdb_tag);
    assign byp4        = !Operand4_Vbit && cdb_valid && (Operand4_Tag == cdb_tag);
    assign issue_ready = any_free;
`else
    assign byp3        = 1'b0;
    assign byp4        = 1'b0;
    // Holding off issue during a broadcast guarantees no result slips past a new entry.
    assign issue_ready = any_free && !cdb_valid;
`endif

    assign in_v3    = Operand3_Vbit || byp3;
    assign in_v4    = Operand4_Vbit || byp4;
    assign in_val3  = Operand3_Vbit ? Operand3 : cdb_data;
    assign in_val4  = Operand4_Vbit ? Operand4 : cdb_data;
    assign do_issue = issue_valid && issue_ready;
    assign do_disp  = !fu_busy && any_rdy;
    assign issue_tag = BASE + TAG_W'(free_idx);
    assign rs_full   = &busy;
    assign rs_count  = count;

    // Control state and dispatch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy           <= '0;
            v3             <= '0;
            v4             <= '0;
            dispatch_valid <= 1'b0;
            dispatch_tag   <= '0;
            dispatch_op3   <= '0;
            dispatch_op4   <= '0;
        end else begin
            dispatch_valid <= do_disp;
            if (do_disp) begin
                dispatch_tag <= BASE + TAG_W'(rdy_idx);
                dispatch_op3 <= val3[rdy_idx];
                dispatch_op4 <= val4[rdy_idx];
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (do_disp && rdy_idx == IDX_W'(i)) begin
                    busy[i] <= 1'b0;
                end
                if (do_issue && free_idx == IDX_W'(i)) begin
                    busy[i] <= 1'b1;
                    v3[i]   <= in_v3;
                    v4[i]   <= in_v4;
                end else begin
                    if (snoop3[i]) v3[i] <= 1'b1;
                    if (snoop4[i]) v4[i] <= 1'b1;
                end
            end
        end
    end

    // Operand payload; validity is tracked by the V bits, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && free_idx == IDX_W'(i)) begin
                val3[i] <= in_val3;
                val4[i] <= in_val4;
                tag3[i] <= Operand3_Tag;
                tag4[i] <= Operand4_Tag;
            end else begin
                if (snoop3[i]) val3[i] <= cdb_data;
                if (snoop4[i]) val4[i] <= cdb_data;
            end
        end
    end

endmodule

// File: tb/tb_param_reservation_station.sv
// Directed bench for param_reservation_station (DEPTH=2, TAG_BASE=1); honours RS_CDB_BYPASS_EN.
module tb_param_reservation_station;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_tag;
    logic [7:0] Operand3, Operand4;
    logic [2:0] Operand3_Tag, Operand4_Tag;
    logic       Operand3_Vbit, Operand4_Vbit;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [7:0] cdb_data;
    logic       fu_busy;
    logic       dispatch_valid;
    logic [2:0] dispatch_tag;
    logic [7:0] dispatch_op3, dispatch_op4;
    logic       rs_full;
    logic [1:0] rs_count;

    int total = 0;
    int bad   = 0;

    param_reservation_station #(
        .DATA_W(8), .TAG_W(3), .DEPTH(2), .TAG_BASE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .Operand3(Operand3), .Operand4(Operand4),
        .Operand3_Tag(Operand3_Tag), .Operand4_Tag(Operand4_Tag),
        .Operand3_Vbit(Operand3_Vbit), .Operand4_Vbit(Operand4_Vbit),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_busy(fu_busy),
        .dispatch_valid(dispatch_valid), .dispatch_tag(dispatch_tag),
        .dispatch_op3(dispatch_op3), .dispatch_op4(dispatch_op4),
        .rs_full(rs_full), .rs_count(rs_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [7:0] o3, input logic v3b, input logic [2:0] t3,
                             input logic [7:0] o4, input logic v4b, input logic [2:0] t4);
        issue_valid   = v;
        Operand3      = o3;
        Operand3_Vbit = v3b;
        Operand3_Tag  = t3;
        Operand4      = o4;
        Operand4_Vbit = v4b;
        Operand4_Tag  = t4;
    endtask

    task automatic set_cdb(input logic v, input logic [2:0] t, input logic [7:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic chk_disp(input string name, input logic [2:0] t, input logic [7:0] o3, input logic [7:0] o4);
        chk({name, "_dv"},  32'(dispatch_valid), 32'd1);
        chk({name, "_tag"}, 32'(dispatch_tag), 32'(t));
        chk({name, "_op3"}, 32'(dispatch_op3), 32'(o3));
        chk({name, "_op4"}, 32'(dispatch_op4), 32'(o4));
    endtask

    initial begin
        reset   = 1'b1;
        fu_busy = 1'b0;
        set_issue(1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        set_cdb(1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("rst_dv",    32'(dispatch_valid), 32'd0);
        chk("rst_dtag",  32'(dispatch_tag), 32'd0);
        chk("rst_op3",   32'(dispatch_op3), 32'd0);
        chk("rst_op4",   32'(dispatch_op4), 32'd0);
        chk("rst_full",  32'(rs_full), 32'd0);
        chk("rst_count", 32'(rs_count), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Both operands valid: ready after the issue edge, dispatched on the next.
        set_issue(1'b1, 8'h05, 1'b1, 3'd0, 8'h03, 1'b1, 3'd0);
        #1;
        chk("t1_itag",  32'(issue_tag), 32'd1);
        chk("t1_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("t1_cnt1", 32'(rs_count), 32'd1);
        chk("t1_dv0",  32'(dispatch_valid), 32'd0);
        tick();
        chk_disp("t1", 3'd1, 8'h05, 8'h03);
        chk("t1_cnt0", 32'(rs_count), 32'd0);
        tick();
        chk("t1_pulse", 32'(dispatch_valid), 32'd0);
        chk("t1_hold",  32'(dispatch_op3), 32'h05);

        // Operand waits on tag 6, resolved by a broadcast.
        set_issue(1'b1, 8'h00, 1'b0, 3'd6, 8'h22, 1'b1, 3'd0);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("t2_wait_dv", 32'(dispatch_valid), 32'd0);
        chk("t2_wait_cnt", 32'(rs_count), 32'd1);
        set_cdb(1'b1, 3'd6, 8'hA7);
        tick();
        set_cdb(1'b0, 3'd0, 8'h00);
        chk("t2_snoop_dv", 32'(dispatch_valid), 32'd0);
        tick();
        chk_disp("t2", 3'd1, 8'hA7, 8'h22);
        tick();

        // Fill while FU busy, ignored third issue, in-order drain.
        fu_busy = 1'b1;
        set_issue(1'b1, 8'h10, 1'b1, 3'd0, 8'h20, 1'b1, 3'd0);
        tick();
        set_issue(1'b1, 8'h30, 1'b1, 3'd0, 8'h40, 1'b1, 3'd0);
        #1;
        chk("t3_itag2", 32'(issue_tag), 32'd2);
        tick();
        chk("t3_full",  32'(rs_full), 32'd1);
        chk("t3_cnt2",  32'(rs_count), 32'd2);
        chk("t3_nordy", 32'(issue_ready), 32'd0);
        set_issue(1'b1, 8'h55, 1'b1, 3'd0, 8'h66, 1'b1, 3'd0);
        tick();
        issue_valid = 1'b0;
        chk("t3_ign_cnt", 32'(rs_count), 32'd2);
        chk("t3_busy_dv", 32'(dispatch_valid), 32'd0);
        fu_busy = 1'b0;
        tick();
        chk_disp("t3a", 3'd1, 8'h10, 8'h20);
        chk("t3_cnt1", 32'(rs_count), 32'd1);
        tick();
        chk_disp("t3b", 3'd2, 8'h30, 8'h40);
        chk("t3_cnt0", 32'(rs_count), 32'd0);
        tick();
        chk("t3_end_dv", 32'(dispatch_valid), 32'd0);

        // Simultaneous issue and dispatch; freed entry 0 is not reused on that edge.
        fu_busy = 1'b1;
        set_issue(1'b1, 8'h71, 1'b1, 3'd0, 8'h72, 1'b1, 3'd0);
        tick();
        fu_busy = 1'b0;
        set_issue(1'b1, 8'h81, 1'b1, 3'd0, 8'h82, 1'b1, 3'd0);
        #1;
        chk("t4_itag", 32'(issue_tag), 32'd2);
        tick();
        issue_valid = 1'b0;
        chk_disp("t4a", 3'd1, 8'h71, 8'h72);
        chk("t4_cnt_same", 32'(rs_count), 32'd1);
        tick();
        chk_disp("t4b", 3'd2, 8'h81, 8'h82);
        tick();

        // Two entries waiting on tag 5; entry 2 waits with both operands.
        set_issue(1'b1, 8'h00, 1'b0, 3'd5, 8'h01, 1'b1, 3'd0);
        tick();
        set_issue(1'b1, 8'h00, 1'b0, 3'd5, 8'h00, 1'b0, 3'd5);
        tick();
        issue_valid = 1'b0;
        set_cdb(1'b1, 3'd3, 8'hEE);
        tick();
        chk("t5_nomatch_dv",  32'(dispatch_valid), 32'd0);
        chk("t5_nomatch_cnt", 32'(rs_count), 32'd2);
        set_cdb(1'b1, 3'd5, 8'h99);
        tick();
        set_cdb(1'b0, 3'd0, 8'h00);
        chk("t5_snoop_dv", 32'(dispatch_valid), 32'd0);
        tick();
        chk_disp("t5a", 3'd1, 8'h99, 8'h01);
        tick();
        chk_disp("t5b", 3'd2, 8'h99, 8'h99);
        tick();
        chk("t5_end_dv", 32'(dispatch_valid), 32'd0);

        // Issue coinciding with the broadcast of its producer tag.
        set_issue(1'b1, 8'h00, 1'b0, 3'd4, 8'h02, 1'b1, 3'd0);
        set_cdb(1'b1, 3'd4, 8'h11);
        #1;
`ifdef RS_CDB_BYPASS_EN
        chk("t6_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        set_cdb(1'b0, 3'd0, 8'h00);
        chk("t6_cnt", 32'(rs_count), 32'd1);
`else
        chk("t6_ready", 32'(issue_ready), 32'd0);
        tick();
        set_cdb(1'b0, 3'd0, 8'h00);
        chk("t6_cnt_ign", 32'(rs_count), 32'd0);
        set_issue(1'b1, 8'h11, 1'b1, 3'd0, 8'h02, 1'b1, 3'd0);
        tick();
        issue_valid = 1'b0;
        chk("t6_cnt", 32'(rs_count), 32'd1);
`endif
        tick();
        chk_disp("t6", 3'd1, 8'h11, 8'h02);
        tick();

        // Reset in the middle of a dispatch pulse with an entry still pending.
        fu_busy = 1'b1;
        set_issue(1'b1, 8'hC1, 1'b1, 3'd0, 8'hC2, 1'b1, 3'd0);
        tick();
        set_issue(1'b1, 8'hD1, 1'b1, 3'd0, 8'hD2, 1'b1, 3'd0);
        tick();
        issue_valid = 1'b0;
        fu_busy = 1'b0;
        tick();
        chk("t7_pre_dv",  32'(dispatch_valid), 32'd1);
        chk("t7_pre_cnt", 32'(rs_count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_rst_dv",   32'(dispatch_valid), 32'd0);
        chk("t7_rst_cnt",  32'(rs_count), 32'd0);
        chk("t7_rst_full", 32'(rs_full), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t7_post_dv1", 32'(dispatch_valid), 32'd0);
        tick();
        chk("t7_post_dv2", 32'(dispatch_valid), 32'd0);
        chk("t7_post_cnt", 32'(rs_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
